// File: rtl/grid_pkg.sv
// Shared types and colour constants for the grid playfield renderer.
package grid_pkg;

  localparam int POS_W = 4;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t C_BLACK   = '{r: 4'd0,  g: 4'd0, b: 4'd0};
  localparam rgb_t C_RED     = '{r: 4'd15, g: 4'd0, b: 4'd0};
  localparam rgb_t C_BLUE    = '{r: 4'd0,  g: 4'd0, b: 4'd15};
  localparam rgb_t C_MAGENTA = '{r: 4'd15, g: 4'd0, b: 4'd15};
  localparam rgb_t C_GREY    = '{r: 4'd4,  g: 4'd4, b: 4'd4};

endpackage

// File: rtl/player_pos.sv
// One player's grid position: move handshake with a pending latch, applied on frame_tick.
// Latency: applied at the first frame_tick after acceptance; ready stays low while a move is pending.
module player_pos
  import grid_pkg::*;
#(
  parameter int COLS    = 4,
  parameter int ROWS    = 4,
  parameter int WRAP    = 0,
  parameter int RST_COL = 0,
  parameter int RST_ROW = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             move_valid,
  input  dir_t             move_dir,
  output logic             move_ready,
  output logic [POS_W-1:0] col,
  output logic [POS_W-1:0] row
);

  localparam logic [POS_W-1:0] ONE     = POS_W'(1);
  localparam logic [POS_W-1:0] MAX_COL = POS_W'(COLS - 1);
  localparam logic [POS_W-1:0] MAX_ROW = POS_W'(ROWS - 1);

  logic             pending_q, pending_d;
  dir_t             dir_q, dir_d;
  logic [POS_W-1:0] col_q, col_d;
  logic [POS_W-1:0] row_q, row_d;

  always_comb begin
    pending_d = pending_q;
    dir_d     = dir_q;
    col_d     = col_q;
    row_d     = row_q;
    if (frame_tick && pending_q) begin
      pending_d = 1'b0;
      unique case (dir_q)
        DIR_UP:    if (row_q != '0)      row_d = row_q - ONE; else if (WRAP != 0) row_d = MAX_ROW;
        DIR_DOWN:  if (row_q != MAX_ROW) row_d = row_q + ONE; else if (WRAP != 0) row_d = '0;
        DIR_LEFT:  if (col_q != '0)      col_d = col_q - ONE; else if (WRAP != 0) col_d = MAX_COL;
        DIR_RIGHT: if (col_q != MAX_COL) col_d = col_q + ONE; else if (WRAP != 0) col_d = '0;
      endcase
    end
    // A move accepted on the tick cycle itself waits for the following tick.
    if (move_valid && !pending_q) begin
      pending_d = 1'b1;
      dir_d     = move_dir;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= 1'b0;
      dir_q     <= DIR_UP;
      col_q     <= POS_W'(RST_COL);
      row_q     <= POS_W'(RST_ROW);
    end else begin
      pending_q <= pending_d;
      dir_q     <= dir_d;
      col_q     <= col_d;
      row_q     <= row_d;
    end
  end

  assign move_ready = !pending_q;
  assign col        = col_q;
  assign row        = row_q;

endmodule

// File: rtl/grid_drawing.sv
// Grid playfield renderer with two player markers and an overlap blink; 2 clk pixel latency.
// Backpressure: per-player move ready is low while a move waits for the next frame_tick.
module grid_drawing
  import grid_pkg::*;
#(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int COLS         = 4,
  parameter int ROWS         = 4,
  parameter int WRAP         = 0,
  parameter int BLINK_FRAMES = 16,
  parameter int GRID_LINES   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] xcoord,
  input  logic [9:0] ycoord,
  input  logic       nocolor,
  input  logic       frame_tick,
  input  logic       p1_move_valid,
  input  logic [1:0] p1_dir,
  output logic       p1_move_ready,
  input  logic       p2_move_valid,
  input  logic [1:0] p2_dir,
  output logic       p2_move_ready,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue
);

  localparam int CELL_W  = H_ACTIVE / COLS;
  localparam int CELL_H  = V_ACTIVE / ROWS;
  localparam int GRID_W  = COLS * CELL_W;
  localparam int GRID_H  = ROWS * CELL_H;
  localparam int BLINK_W = $clog2(BLINK_FRAMES);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [POS_W-1:0]   ONE        = POS_W'(1);

  logic [POS_W-1:0] p1_col, p1_row, p2_col, p2_row;
  logic [31:0]      x_ext, y_ext;

  player_pos #(
    .COLS(COLS), .ROWS(ROWS), .WRAP(WRAP), .RST_COL(0), .RST_ROW(0)
  ) u_p1 (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .move_valid (p1_move_valid),
    .move_dir   (dir_t'(p1_dir)),
    .move_ready (p1_move_ready),
    .col        (p1_col),
    .row        (p1_row)
  );

  player_pos #(
    .COLS(COLS), .ROWS(ROWS), .WRAP(WRAP), .RST_COL(COLS - 1), .RST_ROW(ROWS - 1)
  ) u_p2 (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .move_valid (p2_move_valid),
    .move_dir   (dir_t'(p2_dir)),
    .move_ready (p2_move_ready),
    .col        (p2_col),
    .row        (p2_row)
  );

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;

  logic [POS_W-1:0] s1_col_q, s1_col_d, s1_row_q, s1_row_d;
  logic [POS_W-1:0] s1_p1c_q, s1_p1c_d, s1_p1r_q, s1_p1r_d;
  logic [POS_W-1:0] s1_p2c_q, s1_p2c_d, s1_p2r_q, s1_p2r_d;
  logic             s1_bord_q, s1_bord_d;
  logic             s1_in_q, s1_in_d;
  logic             s1_noc_q, s1_noc_d;
  rgb_t             rgb_q, rgb_d;
  logic             p1_hit, p2_hit;

  assign x_ext = {22'd0, xcoord};
  assign y_ext = {22'd0, ycoord};

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  // Stage 1: cell lookup by constant-boundary compares, plus a snapshot of both positions.
  always_comb begin
    s1_col_d  = '0;
    s1_row_d  = '0;
    s1_bord_d = 1'b0;
    for (int k = 1; k < COLS; k++)
      if (x_ext >= k * CELL_W) s1_col_d = s1_col_d + ONE;
    for (int k = 1; k < ROWS; k++)
      if (y_ext >= k * CELL_H) s1_row_d = s1_row_d + ONE;
    for (int k = 0; k < COLS; k++)
      if (x_ext == k * CELL_W) s1_bord_d = 1'b1;
    for (int k = 0; k < ROWS; k++)
      if (y_ext == k * CELL_H) s1_bord_d = 1'b1;
    s1_in_d  = (x_ext < GRID_W) && (y_ext < GRID_H);
    s1_noc_d = nocolor;
    s1_p1c_d = p1_col;
    s1_p1r_d = p1_row;
    s1_p2c_d = p2_col;
    s1_p2r_d = p2_row;
  end

  assign p1_hit = (s1_col_q == s1_p1c_q) && (s1_row_q == s1_p1r_q);
  assign p2_hit = (s1_col_q == s1_p2c_q) && (s1_row_q == s1_p2r_q);

  always_comb begin
    rgb_d = C_BLACK;
    if (s1_noc_q || !s1_in_q)           rgb_d = C_BLACK;
    else if (GRID_LINES != 0 && s1_bord_q) rgb_d = C_GREY;
    else if (p1_hit && p2_hit)          rgb_d = blink_phase_q ? C_MAGENTA : C_BLACK;
    else if (p1_hit)                    rgb_d = C_RED;
    else if (p2_hit)                    rgb_d = C_BLUE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      s1_col_q      <= '0;
      s1_row_q      <= '0;
      s1_p1c_q      <= '0;
      s1_p1r_q      <= '0;
      s1_p2c_q      <= '0;
      s1_p2r_q      <= '0;
      s1_bord_q     <= 1'b0;
      s1_in_q       <= 1'b0;
      s1_noc_q      <= 1'b1;
      rgb_q         <= C_BLACK;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      s1_col_q      <= s1_col_d;
      s1_row_q      <= s1_row_d;
      s1_p1c_q      <= s1_p1c_d;
      s1_p1r_q      <= s1_p1r_d;
      s1_p2c_q      <= s1_p2c_d;
      s1_p2r_q      <= s1_p2r_d;
      s1_bord_q     <= s1_bord_d;
      s1_in_q       <= s1_in_d;
      s1_noc_q      <= s1_noc_d;
      rgb_q         <= rgb_d;
    end
  end

  assign red   = rgb_q.r;
  assign green = rgb_q.g;
  assign blue  = rgb_q.b;

endmodule
